// File: rtl/motor_pkg.sv
// Shared direction codes, channel state encoding and steering helpers for the
// dual H-bridge command driver.
package motor_pkg;

    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;
    localparam logic [1:0] DIR_ILL   = 2'b11;

    localparam logic [3:0] CMD_FWD_LEFT  = 4'b1001;
    localparam logic [3:0] CMD_FWD_RIGHT = 4'b1010;
    localparam logic [3:0] CMD_ROTATE    = 4'b0101;

    typedef enum logic [1:0] {
        ST_COAST = 2'b00,
        ST_RUN   = 2'b01,
        ST_DEAD  = 2'b10
    } ch_state_e;

    // An illegal pair is presented to its channel as a coast request.
    function automatic logic [1:0] pair_request(input logic [1:0] pair);
        return (pair == DIR_ILL) ? DIR_COAST : pair;
    endfunction

    function automatic logic has_illegal_pair(input logic [3:0] cmd);
        return (cmd[1:0] == DIR_ILL) || (cmd[3:2] == DIR_ILL);
    endfunction

endpackage

// File: rtl/motor_cmd_driver_channel.sv
// One motor channel: COAST/RUN/DEAD state machine with reversal dead-time
// counter and registered bridge pins / gate.
module motor_channel
    import motor_pkg::*;
#(
    parameter int DEAD_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic [1:0] req,
    output logic [1:0] pins,
    output logic       gate
);

    localparam int DCNT_W = $clog2(DEAD_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEAD_CYCLES - 1);

    ch_state_e         state_q, state_d;
    logic [1:0]        dir_q, dir_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [1:0]        pins_q, pins_d;
    logic              gate_q, gate_d;
    logic              req_is_dir;

    assign req_is_dir = (req == DIR_FWD) || (req == DIR_REV);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_COAST: begin
                if (arm && req_is_dir) begin
                    state_d = ST_RUN;
                    dir_d   = req;
                end
            end
            ST_RUN: begin
                if (req == DIR_COAST) begin
                    state_d = ST_COAST;
                end else if (req_is_dir && (req != dir_q)) begin
                    state_d = ST_DEAD;
                    dcnt_d  = '0;
                end
            end
            ST_DEAD: begin
                // The full dead-time always elapses; only the request at its end matters.
                if (dcnt_q == DCNT_LAST) begin
                    if (req_is_dir) begin
                        state_d = ST_RUN;
                        dir_d   = req;
                    end else begin
                        state_d = ST_COAST;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = ST_COAST;
        endcase
        if (!arm) begin
            state_d = ST_COAST;
        end
        pins_d = (state_d == ST_RUN) ? dir_d : DIR_COAST;
        gate_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COAST;
            dir_q   <= DIR_COAST;
            dcnt_q  <= '0;
            pins_q  <= DIR_COAST;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dcnt_q  <= dcnt_d;
            pins_q  <= pins_d;
            gate_q  <= gate_d;
        end
    end

    assign pins = pins_q;
    assign gate = gate_q;

endmodule

// File: rtl/motor_cmd_driver.sv
// Dual H-bridge command driver: debounces the steering code, drives two
// channel FSMs, gates PWM enables and reports lost path / illegal commands.
module motor_cmd_driver
    import motor_pkg::*;
#(
    parameter int STABLE_CYCLES = 10_000,
    parameter int DEAD_CYCLES   = 100_000,
    parameter int LOST_CYCLES   = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic [3:0] cmd_in,
    input  logic [1:0] en_in,
    output logic [3:0] hb_in,
    output logic [1:0] hb_en,
    output logic       path_lost,
    output logic       fault
);

    localparam int SCNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int LCNT_W = $clog2(LOST_CYCLES + 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STABLE_CYCLES);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOST_CYCLES);

    logic [3:0]        cmd_q, cmd_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [3:0]        cmd_acc_q, cmd_acc_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              fault_q, fault_d;
    logic [1:0]        pins_a, pins_b;
    logic              gate_a, gate_b;

    always_comb begin
        cmd_d     = cmd_q;
        scnt_d    = scnt_q;
        cmd_acc_d = cmd_acc_q;
        if (cmd_in != cmd_q) begin
            cmd_d  = cmd_in;
            scnt_d = '0;
        end else if (scnt_q < SCNT_MAX) begin
            scnt_d = scnt_q + 1'b1;
            if (scnt_d == SCNT_MAX) begin
                cmd_acc_d = cmd_q;
            end
        end
    end

    // Counting starts the edge after all-stop is accepted; a nonzero accept clears at once.
    always_comb begin
        lcnt_d = lcnt_q;
        if (cmd_acc_d != 4'b0000) begin
            lcnt_d = '0;
        end else if ((cmd_acc_q == 4'b0000) && (lcnt_q < LCNT_MAX)) begin
            lcnt_d = lcnt_q + 1'b1;
        end
        fault_d = fault_q | has_illegal_pair(cmd_acc_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= 4'b0000;
            scnt_q    <= '0;
            cmd_acc_q <= 4'b0000;
            lcnt_q    <= '0;
            fault_q   <= 1'b0;
        end else begin
            cmd_q     <= cmd_d;
            scnt_q    <= scnt_d;
            cmd_acc_q <= cmd_acc_d;
            lcnt_q    <= lcnt_d;
            fault_q   <= fault_d;
        end
    end

    motor_channel #(.DEAD_CYCLES(DEAD_CYCLES)) u_ch_a (
        .clk  (clk),
        .rst  (rst),
        .arm  (arm),
        .req  (pair_request(cmd_acc_q[1:0])),
        .pins (pins_a),
        .gate (gate_a)
    );

    motor_channel #(.DEAD_CYCLES(DEAD_CYCLES)) u_ch_b (
        .clk  (clk),
        .rst  (rst),
        .arm  (arm),
        .req  (pair_request(cmd_acc_q[3:2])),
        .pins (pins_b),
        .gate (gate_b)
    );

    assign hb_in     = {pins_b, pins_a};
    assign hb_en     = {gate_b & en_in[1], gate_a & en_in[0]};
    assign path_lost = (lcnt_q == LCNT_MAX);
    assign fault     = fault_q;

endmodule

// File: tb/tb_motor_cmd_driver.sv
// Directed bench for motor_cmd_driver with short filter, dead and lost windows.
module tb_motor_cmd_driver;
    import motor_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm;
    logic [3:0] cmd_in;
    logic [1:0] en_in;
    logic [3:0] hb_in;
    logic [1:0] hb_en;
    logic       path_lost;
    logic       fault;

    int vectors     = 0;
    int miscompares = 0;

    motor_cmd_driver #(
        .STABLE_CYCLES(4),
        .DEAD_CYCLES  (8),
        .LOST_CYCLES  (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .cmd_in    (cmd_in),
        .en_in     (en_in),
        .hb_in     (hb_in),
        .hb_en     (hb_en),
        .path_lost (path_lost),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        arm    = 1'b0;
        cmd_in = 4'b0000;
        en_in  = 2'b00;
        step(2);

        // Reset state, then first command.
        check("rst_hb_in", hb_in, 4'b0000);
        check("rst_hb_en", {2'b00, hb_en}, 4'b0000);
        check("rst_lost", {3'b000, path_lost}, 4'b0000);
        check("rst_fault", {3'b000, fault}, 4'b0000);
        rst    = 1'b0;
        cmd_in = CMD_FWD_LEFT;
        en_in  = 2'b11;
        arm    = 1'b1;
        step(5);
        check("start_edge5", hb_in, 4'b0000);
        step(1);
        check("start_edge6", hb_in, 4'b1001);
        check("start_en", {2'b00, hb_en}, 4'b0011);
        check("start_fault", {3'b000, fault}, 4'b0000);
        en_in = 2'b01;
        #1;
        check("pwm_pass", {2'b00, hb_en}, 4'b0001);
        en_in = 2'b11;
        #1;

        // Three-cycle glitch towards reverse is never accepted.
        cmd_in = 4'b0110;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) cmd_in = CMD_FWD_LEFT;
            step(1);
            check("glitch_hold", hb_in, 4'b1001);
        end

        // Held reversal: 8 cycles of coast then the new direction.
        cmd_in = 4'b0110;
        step(5);
        check("rev_pre", hb_in, 4'b1001);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("rev_dead_in", hb_in, 4'b0000);
            check("rev_dead_en", {2'b00, hb_en}, 4'b0000);
        end
        step(1);
        check("rev_run", hb_in, 4'b0110);
        check("rev_run_en", {2'b00, hb_en}, 4'b0011);

        // All-stop and path_lost timing.
        cmd_in = 4'b0000;
        step(5);
        check("stop_pre", hb_in, 4'b0110);
        step(1);
        check("stop_coast", hb_in, 4'b0000);
        check("lost_early", {3'b000, path_lost}, 4'b0000);
        step(18);
        check("lost_19", {3'b000, path_lost}, 4'b0000);
        step(1);
        check("lost_20", {3'b000, path_lost}, 4'b0001);
        step(3);
        check("lost_sat", {3'b000, path_lost}, 4'b0001);
        cmd_in = CMD_FWD_RIGHT;
        step(4);
        check("lost_pre_acc", {3'b000, path_lost}, 4'b0001);
        step(1);
        check("lost_drop", {3'b000, path_lost}, 4'b0000);
        step(1);
        check("right_run", hb_in, 4'b1010);

        // Illegal pair on B: fault sets, B coasts, A reverses through dead-time.
        cmd_in = 4'b1101;
        step(4);
        check("fault_pre", {3'b000, fault}, 4'b0000);
        step(1);
        check("fault_set", {3'b000, fault}, 4'b0001);
        step(1);
        check("ill_dead", hb_in, 4'b0000);
        step(7);
        check("ill_dead_end", hb_in, 4'b0000);
        step(1);
        check("ill_a_run", hb_in, 4'b0001);
        check("ill_en", {2'b00, hb_en}, 4'b0001);
        cmd_in = CMD_ROTATE;
        step(6);
        check("rotate_run", hb_in, 4'b0101);
        check("fault_sticky", {3'b000, fault}, 4'b0001);
        check("rotate_en", {2'b00, hb_en}, 4'b0011);
        rst = 1'b1;
        step(1);
        check("rst2_fault", {3'b000, fault}, 4'b0000);
        check("rst2_hb_in", hb_in, 4'b0000);
        check("rst2_hb_en", {2'b00, hb_en}, 4'b0000);
        rst = 1'b0;
        step(6);
        check("rotate_again", hb_in, 4'b0101);

        // Reset during dead-time discards the pending reversal.
        cmd_in = CMD_FWD_RIGHT;
        step(6);
        check("dead_mid", hb_in, 4'b0000);
        step(2);
        rst = 1'b1;
        step(1);
        check("dead_rst_in", hb_in, 4'b0000);
        check("dead_rst_en", {2'b00, hb_en}, 4'b0000);
        check("dead_rst_st_a", {2'b00, dut.u_ch_a.state_q}, {2'b00, ST_COAST});
        check("dead_rst_st_b", {2'b00, dut.u_ch_b.state_q}, {2'b00, ST_COAST});
        rst    = 1'b0;
        cmd_in = 4'b0110;
        step(5);
        check("rearm_pre", hb_in, 4'b0000);
        step(1);
        check("rearm_run", hb_in, 4'b0110);
        check("rearm_en", {2'b00, hb_en}, 4'b0011);

        // Disarm forces coast; re-arm resumes without dead-time.
        arm = 1'b0;
        step(1);
        check("disarm_in", hb_in, 4'b0000);
        check("disarm_en", {2'b00, hb_en}, 4'b0000);
        arm = 1'b1;
        step(1);
        check("arm_run", hb_in, 4'b0110);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
